// File: rtl/alu32_seq_if.sv
// Request/response bundle between the operand mux and alu32_seq.
// ALU32_OVF_EN adds the registered signed-overflow flag.
interface alu32_seq_if #(parameter int WIDTH = 32);
    logic             start;
    logic [3:0]       aluop;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;
    logic             done;
`ifdef ALU32_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, aluop, a, b,
`ifdef ALU32_OVF_EN
        input  ovf,
`endif
        input  result, zero, busy, done
    );

    modport slave (
        input  start, aluop, a, b,
`ifdef ALU32_OVF_EN
        output ovf,
`endif
        output result, zero, busy, done
    );
endinterface

// File: rtl/alu32_seq.sv
// Execution-stage ALU: 1-cycle add/sub/and/or/slt, WIDTH-cycle shift-add multiply.
// Optional signed-overflow flag on add/sub is enabled by defining ALU32_OVF_EN.
module alu32_seq #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    alu32_seq_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] acc, acc_n;
    logic [WIDTH-1:0] mcand, mcand_n;
    logic [WIDTH-1:0] mplier, mplier_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] result_q, result_n;
    logic             zero_q, zero_n;
    logic             done_q, done_n;

    logic [WIDTH-1:0] sum, diff, op_res, acc_step;
    logic             slt;

`ifdef ALU32_OVF_EN
    logic ovf_q, ovf_n, op_ovf;
`endif

    // Single-cycle result from the live operands; only used at an accepting edge.
    always_comb begin
        sum    = bus.a + bus.b;
        diff   = bus.a - bus.b;
        slt    = $signed(bus.a) < $signed(bus.b);
        op_res = '0;
        case (bus.aluop)
            OP_ADD:  op_res = sum;
            OP_SUB:  op_res = diff;
            OP_AND:  op_res = bus.a & bus.b;
            OP_OR:   op_res = bus.a | bus.b;
            OP_SLT:  op_res = {{(WIDTH-1){1'b0}}, slt};
            default: op_res = '0;
        endcase
    end

`ifdef ALU32_OVF_EN
    always_comb begin
        op_ovf = 1'b0;
        case (bus.aluop)
            OP_ADD:  op_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1]  != bus.a[WIDTH-1]);
            OP_SUB:  op_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
            default: op_ovf = 1'b0;
        endcase
    end
`endif

    assign acc_step = mplier[0] ? acc + mcand : acc;

    always_comb begin
        state_n  = state;
        acc_n    = acc;
        mcand_n  = mcand;
        mplier_n = mplier;
        cnt_n    = cnt;
        result_n = result_q;
        zero_n   = zero_q;
        done_n   = 1'b0;
`ifdef ALU32_OVF_EN
        ovf_n    = ovf_q;
`endif
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.aluop == OP_MUL) begin
                        acc_n    = '0;
                        mcand_n  = bus.a;
                        mplier_n = bus.b;
                        cnt_n    = '0;
                        state_n  = MUL;
                    end else begin
                        result_n = op_res;
                        zero_n   = (op_res == '0);
                        done_n   = 1'b1;
`ifdef ALU32_OVF_EN
                        ovf_n    = op_ovf;
`endif
                    end
                end
            end
            MUL: begin
                // Fixed WIDTH iterations; the last one publishes including its own add.
                acc_n    = acc_step;
                mcand_n  = mcand << 1;
                mplier_n = mplier >> 1;
                cnt_n    = cnt + 1'b1;
                if (cnt == CW'(WIDTH - 1)) begin
                    result_n = acc_step;
                    zero_n   = (acc_step == '0);
                    done_n   = 1'b1;
                    state_n  = IDLE;
`ifdef ALU32_OVF_EN
                    ovf_n    = 1'b0;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
`ifdef ALU32_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            acc      <= acc_n;
            mcand    <= mcand_n;
            mplier   <= mplier_n;
            cnt      <= cnt_n;
            result_q <= result_n;
            zero_q   <= zero_n;
            done_q   <= done_n;
`ifdef ALU32_OVF_EN
            ovf_q    <= ovf_n;
`endif
        end
    end

    assign bus.result = result_q;
    assign bus.zero   = zero_q;
    assign bus.done   = done_q;
    assign bus.busy   = (state == MUL);
`ifdef ALU32_OVF_EN
    assign bus.ovf    = ovf_q;
`endif
endmodule

// File: tb/tb_alu32_seq.sv
// Directed bench for alu32_seq: transaction-level model checked every cycle,
// plus hand-computed literal expectations.
module tb_alu32_seq;
    localparam int W = 32;
    localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110, AND_ = 4'b0000,
                           OR_ = 4'b0001, SLT = 4'b0111, MUL = 4'b1000;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    alu32_seq_if #(.WIDTH(W)) bus ();
    alu32_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        case (op)
            ADD:     return x + y;
            SUB:     return x - y;
            AND_:    return x & y;
            OR_:     return x | y;
            SLT:     return ($signed(x) < $signed(y)) ? 1 : 0;
            default: return 0;
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx, sy, r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (op == ADD)      r = sx + sy;
        else if (op == SUB) r = sx - sy;
        else                return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    // Transaction model: a multiply publishes its product W edges after acceptance.
    logic [W-1:0] m_result, m_prod;
    logic         m_zero, m_done, m_ovf;
    int           m_left;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_result <= 0; m_zero <= 1'b1; m_done <= 1'b0; m_ovf <= 1'b0; m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_result <= m_prod; m_zero <= (m_prod == 0); m_done <= 1'b1; m_ovf <= 1'b0;
                end
            end else if (bus.start) begin
                if (bus.aluop == MUL) begin
                    m_prod <= bus.a * bus.b;
                    m_left <= W;
                end else begin
                    m_result <= ref_op(bus.aluop, bus.a, bus.b);
                    m_zero   <= (ref_op(bus.aluop, bus.a, bus.b) == 0);
                    m_ovf    <= ref_ovf(bus.aluop, bus.a, bus.b);
                    m_done   <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model.result", bus.result, m_result);
            chk("model.zero", W'(bus.zero), W'(m_zero));
            chk("model.busy", W'(bus.busy), W'(m_left != 0));
            chk("model.done", W'(bus.done), W'(m_done));
`ifdef ALU32_OVF_EN
            chk("model.ovf", W'(bus.ovf), W'(m_ovf));
`endif
        end
    end

    task automatic drive(input logic st, input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        bus.start = st; bus.aluop = op; bus.a = x; bus.b = y;
        @(negedge clk);
        #1;
    endtask

    // Counts busy cycles from now until busy drops, with a cycle budget.
    task automatic wait_mul(output int n);
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        if (n >= 100) chk("mul.timeout", 1, 0);
    endtask

    int n, dones;

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.aluop = ADD; bus.a = 0; bus.b = 0;
        @(negedge clk);
        chk_en = 1'b1;
        drive(0, ADD, 0, 0);
        chk("rst.result", bus.result, 0);
        chk("rst.zero", W'(bus.zero), 1);
        chk("rst.busy", W'(bus.busy), 0);
        chk("rst.done", W'(bus.done), 0);
        rst_n = 1'b1;
        drive(0, ADD, 0, 0);
        drive(0, ADD, 0, 0);
        chk("idle.result", bus.result, 0);
        chk("idle.zero", W'(bus.zero), 1);

        drive(1, ADD, 32'h7, 32'h5);
        chk("add.result", bus.result, 32'hC);
        chk("add.done", W'(bus.done), 1);
        drive(1, SUB, 5, 5);
        chk("sub.result", bus.result, 0);
        chk("sub.zero", W'(bus.zero), 1);
        chk("sub.done", W'(bus.done), 1);
        drive(1, AND_, 32'hF0F0, 32'h0FF0);
        chk("and.result", bus.result, 32'h00F0);
        drive(1, OR_, 32'hF000, 32'h000F);
        chk("or.result", bus.result, 32'hF00F);
        drive(1, SLT, 32'hFFFF_FFFF, 1);
        chk("slt.neg", bus.result, 1);
        drive(1, SLT, 1, 32'hFFFF_FFFF);
        chk("slt.pos", bus.result, 0);
        chk("slt.zero", W'(bus.zero), 1);
        drive(1, 4'b1111, 32'h1234, 32'h5678);
        chk("undef.result", bus.result, 0);
        drive(0, ADD, 0, 0);
        chk("idle.done", W'(bus.done), 0);

        drive(1, MUL, 12345, 6789);
        bus.start = 1'b0;
        wait_mul(n);
        chk("mul.busy_cycles", n, 32);
        chk("mul.result", bus.result, 32'h04FE_D79D);
        chk("mul.done", W'(bus.done), 1);
        drive(0, ADD, 0, 0);
        chk("mul.done_once", W'(bus.done), 0);

        drive(1, MUL, 32'hFFFF_FFFF, 2);
        bus.start = 1'b0;
        wait_mul(n);
        chk("mul.neg", bus.result, 32'hFFFF_FFFE);
        drive(1, MUL, 0, 32'hFFFF_FFFF);
        bus.start = 1'b0;
        wait_mul(n);
        chk("mul.zero_res", bus.result, 0);
        chk("mul.zero_flag", W'(bus.zero), 1);

        // start with add mid-multiply and operand changes must be ignored
        drive(1, MUL, 3, 4);
        for (int i = 0; i < 8; i++) drive(0, MUL, 3, 4);
        drive(1, ADD, 1, 1);
        drive(1, ADD, 99, 77);
        bus.start = 1'b0;
        dones = 0;
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            if (bus.done) dones++;
            @(negedge clk);
            #1;
        end
        if (n >= 100) chk("rej.timeout", 1, 0);
        for (int i = 0; i < 4; i++) begin
            if (bus.done) dones++;
            drive(0, ADD, 0, 0);
        end
        chk("rej.result", bus.result, 12);
        chk("rej.dones", dones, 1);

        drive(1, MUL, 100, 100);
        bus.start = 1'b0;
        for (int i = 0; i < 14; i++) drive(0, ADD, 0, 0);
        rst_n = 1'b0;
        drive(0, ADD, 0, 0);
        chk("abort.busy", W'(bus.busy), 0);
        chk("abort.result", bus.result, 0);
        chk("abort.zero", W'(bus.zero), 1);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) dones++;
            drive(0, ADD, 0, 0);
        end
        chk("abort.dones", dones, 0);

`ifdef ALU32_OVF_EN
        drive(1, ADD, 32'h7FFF_FFFF, 1);
        chk("ovf.add_res", bus.result, 32'h8000_0000);
        chk("ovf.add", W'(bus.ovf), 1);
        drive(1, SUB, 32'h8000_0000, 1);
        chk("ovf.sub", W'(bus.ovf), 1);
        drive(1, ADD, 1, 1);
        chk("ovf.none", W'(bus.ovf), 0);
        drive(0, ADD, 0, 0);
`endif

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
